// File: rtl/scope_pkg.sv
// Shared constants for the scope capture path: state encoding,
// trigger slope selectors and the filter sample width.
package scope_pkg;

  localparam int SCOPE_DATA_SIZE = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic SLOPE_RISING  = 1'b0;
  localparam logic SLOPE_FALLING = 1'b1;

endpackage

// File: rtl/scope_capture_ram.sv
// Capture memory: one write port, one registered read port,
// both on clk; shaped for block-RAM inference.
module scope_capture_ram #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_waddr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_SIZE-1:0] i_raddr,
  output logic [DATA_SIZE-1:0] o_rdata
);

  logic [DATA_SIZE-1:0] r_mem [0:(1<<ADDR_SIZE)-1];
  logic [DATA_SIZE-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_re)
      r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/scope_trigger_capture.sv
// Single-shot level/slope triggered frame capture with pre-trigger.
// Define SCOPE_AUTO_TRIG_EN to enable the auto-trigger timeout.
module scope_trigger_capture
  import scope_pkg::*;
#(
  parameter int DATA_SIZE    = SCOPE_DATA_SIZE,
  parameter int ADDR_SIZE    = 10,
  parameter int DEPTH        = 1024,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [DATA_SIZE-1:0] sample_in,
  input  logic                 sample_valid,
  input  logic [DATA_SIZE-1:0] trig_level,
  input  logic                 trig_slope,
  input  logic [ADDR_SIZE-1:0] pretrig_depth,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 busy,
  output logic                 capture_done,
  output logic [ADDR_SIZE-1:0] trig_addr,
  output logic                 trig_forced
);

  localparam logic [ADDR_SIZE:0]   DEPTH_W = DEPTH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0]   PONE    = 1;
  localparam logic [ADDR_SIZE-1:0] AONE    = 1;
  localparam logic [ADDR_SIZE-1:0] MAX_PD  = ADDR_SIZE'(DEPTH - 1);

  logic [2:0]           r_state;
  logic                 r_sv_d;
  logic                 r_prev_v;
  logic [DATA_SIZE-1:0] r_prev;
  logic [DATA_SIZE-1:0] r_level;
  logic                 r_slope;
  logic [ADDR_SIZE-1:0] r_pd;
  logic [ADDR_SIZE-1:0] r_wptr;
  logic [ADDR_SIZE-1:0] r_taddr;
  logic [ADDR_SIZE-1:0] r_fcnt;
  logic [ADDR_SIZE:0]   r_pcnt;
  logic                 r_rd_zero;

  logic                 w_acc;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_we;
  logic                 w_arm_ok;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_hit;
  logic                 w_force;
  logic [ADDR_SIZE-1:0] w_pd_in;
  logic [ADDR_SIZE-1:0] w_fcnt_nx;
  logic [ADDR_SIZE:0]   w_post_tgt;
  logic [ADDR_SIZE:0]   w_pcnt_nx;
  logic [ADDR_SIZE-1:0] w_raddr;
  logic [DATA_SIZE-1:0] w_ram_q;

  assign w_acc    = sample_valid & ~r_sv_d;
  assign w_busy   = (r_state == ST_FILL) |
                    (r_state == ST_WAIT) |
                    (r_state == ST_POST);
  assign w_done   = (r_state == ST_DONE);
  assign w_we     = w_acc & w_busy & ~abort;
  assign w_arm_ok = arm & ~abort &
                    ((r_state == ST_IDLE) | w_done);

  assign w_rise = r_prev_v & (r_prev < r_level) &
                  (sample_in >= r_level);
  assign w_fall = r_prev_v & (r_prev > r_level) &
                  (sample_in <= r_level);
  assign w_hit  = (r_slope == SLOPE_FALLING) ? w_fall : w_rise;

  assign w_pd_in    = (pretrig_depth > MAX_PD) ? MAX_PD
                                               : pretrig_depth;
  assign w_fcnt_nx  = r_fcnt + ADDR_SIZE'(w_we);
  assign w_post_tgt = DEPTH_W - {1'b0, r_pd};
  assign w_pcnt_nx  = r_pcnt + PONE;

  // Frame index 0 is pd samples before the trigger sample.
  assign w_raddr = r_taddr - r_pd + rd_addr;

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_END = TW'(AUTO_TIMEOUT);

  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_nx;
  logic          r_forced;

  assign w_tmo_nx    = r_tmo + TW'(1);
  assign w_force     = (w_tmo_nx == TMO_END);
  assign trig_forced = r_forced;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tmo    <= '0;
      r_forced <= 1'b0;
    end else if (abort) begin
      r_tmo    <= r_tmo;
    end else if (w_arm_ok) begin
      r_tmo    <= '0;
      r_forced <= 1'b0;
    end else if (w_we && r_state == ST_WAIT) begin
      r_tmo <= w_tmo_nx;
      // A genuine trigger on the same sample takes precedence.
      if (w_force && !w_hit)
        r_forced <= 1'b1;
    end
  end
`else
  logic w_unused_tmo;

  assign w_force      = 1'b0;
  assign w_unused_tmo = ^AUTO_TIMEOUT;
  assign trig_forced  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_sv_d    <= 1'b1;
      r_prev_v  <= 1'b0;
      r_prev    <= '0;
      r_level   <= '0;
      r_slope   <= SLOPE_RISING;
      r_pd      <= '0;
      r_wptr    <= '0;
      r_taddr   <= '0;
      r_fcnt    <= '0;
      r_pcnt    <= '0;
      r_rd_zero <= 1'b1;
    end else begin
      r_sv_d <= sample_valid;
      if (rd_en)
        r_rd_zero <= ~w_done;
      if (abort) begin
        r_state <= ST_IDLE;
      end else if (w_arm_ok) begin
        r_state  <= ST_FILL;
        r_level  <= trig_level;
        r_slope  <= trig_slope;
        r_pd     <= w_pd_in;
        r_fcnt   <= '0;
        r_pcnt   <= '0;
        r_prev_v <= 1'b0;
      end else begin
        if (w_we) begin
          r_wptr   <= r_wptr + AONE;
          r_prev   <= sample_in;
          r_prev_v <= 1'b1;
        end
        unique case (1'b1)
          (r_state == ST_FILL): begin
            r_fcnt <= w_fcnt_nx;
            if (w_fcnt_nx >= r_pd)
              r_state <= ST_WAIT;
          end
          (r_state == ST_WAIT): begin
            if (w_we && (w_hit || w_force)) begin
              r_taddr <= r_wptr;
              r_pcnt  <= PONE;
              // With pd = DEPTH-1 the trigger sample closes the frame.
              r_state <= (w_post_tgt == PONE) ? ST_DONE
                                              : ST_POST;
            end
          end
          (r_state == ST_POST): begin
            if (w_we) begin
              r_pcnt <= w_pcnt_nx;
              if (w_pcnt_nx == w_post_tgt)
                r_state <= ST_DONE;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  scope_capture_ram #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_wptr),
    .i_wdata(sample_in),
    .i_re   (rd_en & w_done),
    .i_raddr(w_raddr),
    .o_rdata(w_ram_q)
  );

  assign rd_data      = r_rd_zero ? '0 : w_ram_q;
  assign busy         = w_busy;
  assign capture_done = w_done;
  assign trig_addr    = r_taddr;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Bench for scope_trigger_capture with DEPTH=16, AUTO_TIMEOUT=32.
// Frames are predicted from the accepted-sample list at sample level.
module tb_scope_trigger_capture;
  import scope_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int DEP = 16;
  localparam int ATO = 32;

`ifdef SCOPE_AUTO_TRIG_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          arm;
  logic          abort;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic [DW-1:0] trig_level;
  logic          trig_slope;
  logic [AW-1:0] pretrig_depth;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          capture_done;
  logic [AW-1:0] trig_addr;
  logic          trig_forced;

  int checks   = 0;
  int failures = 0;
  int m_wptr   = 0;
  logic [15:0] xs[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  scope_trigger_capture #(
    .DATA_SIZE(DW),
    .ADDR_SIZE(AW),
    .DEPTH(DEP),
    .AUTO_TIMEOUT(ATO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .arm(arm),
    .abort(abort),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .trig_level(trig_level),
    .trig_slope(trig_slope),
    .pretrig_depth(pretrig_depth),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .capture_done(capture_done),
    .trig_addr(trig_addr),
    .trig_forced(trig_forced)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    rd_en = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic send(input logic [15:0] x, input int hold);
    sample_in = x;
    sample_valid = 1'b1;
    repeat (hold > 1 ? hold : 1) @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_arm(input int pd, input logic [15:0] lvl,
                           input logic sl);
    trig_level = lvl;
    trig_slope = sl;
    pretrig_depth = AW'(pd);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, capture_done, 0);
    chk({tag, "_forced"}, trig_forced, 0);
    chk({tag, "_trig_addr"}, trig_addr, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  // Trigger index in xs (or -1): first sample in the waiting phase
  // that crosses the level with a valid predecessor, or the timeout.
  function automatic void model(input int pd, input logic [15:0] lvl,
                                input logic sl, output int t,
                                output bit forced);
    t = -1;
    forced = 1'b0;
    for (int i = pd; i < xs.size(); i++) begin
      if (i >= 1 && (sl ? (xs[i-1] > lvl && xs[i] <= lvl)
                        : (xs[i-1] < lvl && xs[i] >= lvl))) begin
        t = i;
        return;
      end
      if (AUTO && (i - pd + 1) == ATO) begin
        t = i;
        forced = 1'b1;
        return;
      end
    end
  endfunction

  task automatic capture(input string tag, input int pd_in,
                         input logic [15:0] lvl, input logic sl,
                         input int hold, input int arm_mid,
                         input int abort_after);
    int pd, t, last, n, w0;
    bit forced;
    logic [DW-1:0] d;
    pd = (pd_in > DEP - 1) ? DEP - 1 : pd_in;
    model(pd, lvl, sl, t, forced);
    last = (t < 0) ? -1 : t + DEP - pd - 1;
    n = (last < 0) ? xs.size() : last + 1;
    if (n > xs.size()) n = xs.size();
    if (abort_after >= 0 && abort_after < n) n = abort_after;
    w0 = m_wptr;
    pulse_arm(pd_in, lvl, sl);
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      send(xs[i], (i == 0) ? hold : 1);
      m_wptr = (m_wptr + 1) % DEP;
      chk($sformatf("%s_state_%0d", tag, i), {busy, capture_done},
          (i == last) ? 2'b01 : 2'b10);
      if (i == arm_mid)
        pulse_arm(0, ~lvl, ~sl);
    end
    if (last >= 0 && n == last + 1) begin
      chk({tag, "_trig_addr"}, trig_addr, (w0 + t) % DEP);
      chk({tag, "_forced"}, trig_forced, forced);
      for (int j = 0; j < DEP; j++) begin
        rd(AW'(j), d);
        chk($sformatf("%s_rd_%0d", tag, j), d, xs[t - pd + j]);
      end
    end else begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk({tag, "_abort_state"}, {busy, capture_done}, 2'b00);
      rd(0, d);
      chk({tag, "_abort_rd"}, d, 0);
    end
  endtask

  task automatic ramp_up();
    xs.delete();
    for (int k = 0; k < 24; k++) xs.push_back(16'(k * 16'h1000));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    logic [DW-1:0] d;
    tbl[0] = '{4'd0,  16'h4000};
    tbl[1] = '{4'd1,  16'h5000};
    tbl[2] = '{4'd4,  16'h8000};
    tbl[3] = '{4'd11, 16'hF000};
    tbl[4] = '{4'd15, 16'h3000};

    rstn = 1'b0; arm = 1'b0; abort = 1'b0;
    sample_valid = 1'b1; sample_in = '0;
    trig_level = '0; trig_slope = 1'b0; pretrig_depth = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    reset_checks("reset");
    repeat (5) @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);

    ramp_up();
    capture("nom", 4, 16'h8000, SLOPE_RISING, 1, -1, -1);
    chk("nom_trig_8", trig_addr, 8);
    for (int i = 0; i < 5; i++) begin
      rd(tbl[i].addr, d);
      chk($sformatf("nom_tbl_%0d", i), d, tbl[i].exp);
    end

    xs.delete();
    for (int k = 0; k < 24; k++)
      xs.push_back(16'(16'hF000 - k * 16'h1000));
    capture("fall", 0, 16'h8000, SLOPE_FALLING, 1, -1, -1);
    rd(0, d);
    chk("fall_rd0", d, 16'h8000);

    xs.delete();
    for (int k = 0; k < 40; k++) xs.push_back(16'($urandom));
    capture("bnd", 15, 16'h8000, SLOPE_RISING, 1, 3, -1);

    ramp_up();
    capture("abt", 4, 16'h8000, SLOPE_RISING, 1, -1, 11);

    xs.delete();
    for (int k = 0; k < 60; k++) xs.push_back(16'h1000);
    capture("auto", 4, 16'h8000, SLOPE_RISING, 1, -1, -1);

    pulse_arm(4, 16'h8000, SLOPE_RISING);
    send(16'h1111, 1);
    send(16'h2222, 1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    reset_checks("midrst");
    m_wptr = 0;

    ramp_up();
    capture("rearm", 4, 16'h8000, SLOPE_RISING, 20, -1, -1);
    chk("rearm_trig_8", trig_addr, 8);
    for (int i = 0; i < 5; i++) begin
      rd(tbl[i].addr, d);
      chk($sformatf("rearm_tbl_%0d", i), d, tbl[i].exp);
    end

    for (int r = 0; r < 8; r++) begin
      xs.delete();
      for (int k = 0; k < 64; k++) xs.push_back(16'($urandom));
      capture($sformatf("rnd%0d", r), $urandom_range(0, 15),
              16'($urandom), 1'($urandom_range(0, 1)), 1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
- Downstream consumer of the filter stage. Takes each filtered 16-bit sample (filter result/done) and keeps the samples in a circular capture RAM.
- Detects a level/slope trigger and freezes a frame of DEPTH samples, with a programmable pre-trigger portion.
- Exposes the frame through a trigger-relative read port for the display/AXI readout logic.
- Single-shot: software re-arms after each frame.

Parameters:
DATA_SIZE, 16, sample width (matches filter result width)
ADDR_SIZE, 10, capture RAM address width
DEPTH, 1024, frame length in samples; must equal 2**ADDR_SIZE
AUTO_TIMEOUT, 65535, samples spent in WAIT_TRIG before a forced trigger (SCOPE_AUTO_TRIG_EN only)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
arm  in  1  one-cycle pulse; starts a capture; honoured only in IDLE or DONE
abort  in  1  returns to IDLE from any state; highest priority after reset
sample_in  in  DATA_SIZE  filtered sample (unsigned)
sample_valid  in  1  filter done; a sample is accepted on each 0->1 edge only
trig_level  in  DATA_SIZE  trigger threshold, latched at arm
trig_slope  in  1  0 = rising, 1 = falling; latched at arm
pretrig_depth  in  ADDR_SIZE  samples kept before the trigger; latched at arm
rd_en  in  1  read strobe
rd_addr  in  ADDR_SIZE  frame index; 0 = oldest sample of the frame
rd_data  out  DATA_SIZE  read data, 1-cycle latency
busy  out  1  high in FILL, WAIT_TRIG and POST
capture_done  out  1  high in DONE
trig_addr  out  ADDR_SIZE  physical RAM address of the trigger sample
trig_forced  out  1  frame was closed by the auto-trigger

Behaviour:
- Reset: state IDLE. rd_data, trig_addr, all counters and the write pointer = 0. busy, capture_done, trig_forced = 0. RAM contents are not cleared.
- Accept strobe: acc = sample_valid & ~sample_valid_d. sample_valid_d is registered and resets to 1, so a level held high through reset (filter bypass) does not produce a spurious first sample.
- Write: on every acc while busy, RAM[wptr] <= sample_in and wptr <= wptr+1 (wraps modulo DEPTH). prev <= sample_in.
- arm: latch trig_level, trig_slope and pd = min(pretrig_depth, DEPTH-1). Clear the counters, trig_forced and the prev-valid flag. wptr is not reset.
- States:
  - IDLE -> FILL on arm.
  - FILL: count accepted samples; -> WAIT_TRIG when the count reaches pd. pd = 0 goes to WAIT_TRIG on the cycle after arm.
  - WAIT_TRIG: on each acc, evaluate the trigger against the current sample.
    - Rising: prev_valid & prev < level & sample_in >= level.
    - Falling: prev_valid & prev > level & sample_in <= level.
    - Comparisons are unsigned.
    - On trigger: trig_addr <= wptr (address of the triggering sample), post counter <= 1, -> POST.
    - The first accepted sample after arm never triggers, because prev_valid is 0.
  - POST: count accepted samples, the trigger sample included, until DEPTH-pd have been written; -> DONE on the acc that writes the last one.
  - DONE: no writes; hold until arm (-> FILL) or abort (-> IDLE).
- Frame start address: start = trig_addr - pd mod DEPTH. A read accesses physical RAM[(start + rd_addr) mod DEPTH].
- Read port:
  - In DONE, rd_data is registered one cycle after rd_en.
  - Outside DONE, rd_en loads rd_data with 0.
  - Without rd_en, rd_data holds its value.
- Simultaneous events:
  - abort beats arm and acc.
  - arm while busy is ignored.
  - An acc on the same cycle as the DONE transition is the last write; later accs are dropped.
- Reset mid-capture: return to the reset state immediately; a partial frame is never flagged done.
- RAM: simple dual-port, one write port and one registered read port, both on clk. Inferred block RAM.

Optional Feature:
- Macro: SCOPE_AUTO_TRIG_EN.
- Defined:
  - A timeout counter counts accepted samples in WAIT_TRIG.
  - When it reaches AUTO_TIMEOUT, the current acc is treated as the trigger and trig_forced <= 1.
  - A genuine trigger on the same acc wins, so trig_forced stays 0.
- Not defined: the counter logic is absent, trig_forced is tied 0, and WAIT_TRIG waits indefinitely.

Decomposition:
- Shared package scope_pkg holds:
  - the state encoding (IDLE, FILL, WAIT_TRIG, POST, DONE);
  - slope constants SLOPE_RISING = 0 and SLOPE_FALLING = 1;
  - a default DATA_SIZE localparam shared with the filter stage.
- One sub-module, scope_capture_ram: the dual-port RAM, parameterised DATA_SIZE/ADDR_SIZE.
- Trigger compare and FSM stay in the top level.

Test Plan:
- Nominal rising capture. DEPTH=16, pd=4, level 0x8000, rising. Sample k = (k*0x1000) mod 0x10000, one pulse every 3 cycles. Required: trigger at k=8, capture_done after k=19; rd_addr 0 -> 0x4000, rd_addr 4 -> 0x8000, rd_addr 15 -> 0x3000.
- Falling slope. Same ramp reversed (0xF000 downwards), level 0x8000, pd=0. Required: trigger on the first sample <= 0x8000 after a sample > 0x8000; rd_addr 0 = 0x8000.
- Edge-only accept. sample_valid held high for 20 cycles, then toggled. Required: only one write per 0->1 edge; a level held high out of reset writes nothing.
- Boundaries. pretrig_depth = 0x3FF with DEPTH=16 (ADDR_SIZE=4, pretrig_depth=0xF), then arm while busy, then abort in POST. Required: pd clamps to 15; arm is ignored; abort drives busy=0 and capture_done=0 the next cycle; rd_data reads 0.
- Auto-trigger (SCOPE_AUTO_TRIG_EN, AUTO_TIMEOUT=32). Constant 0x1000 input, level 0x8000. Required: DONE after pd + 32 + (DEPTH-pd-1) samples, trig_forced=1. Without the macro: busy stays 1, capture_done stays 0.
- Reset mid-FILL and re-arm. Required: all outputs at reset values; the next capture behaves identically to the nominal case.
